mem_bridge: RTL and testbench
=============================

// Module: mem_bridge
// PURPOSE
// - Single-outstanding AXI4-Lite master that sits directly upstream of the AXI block RAM slave.
// - Converts a core-side load/store request (valid/ready) into AW/W/B or AR/R transactions.
// - Returns read data and error status on a valid/ready response channel.
// - Serves the rv32 core's data-memory port.
// PARAMETERS
// - ADDR_WIDTH  32   byte address width on both sides
// - DATA_WIDTH  32   data width; strobe width is DATA_WIDTH/8
// - TIMEOUT     256  cycles before a stalled transaction is abandoned (only with MEM_BRIDGE_TIMEOUT_EN)
// PORTS
// - clk        in   1             clock
// - rst        in   1             asynchronous, active-high reset
// - req_valid  in   1             core request valid
// - req_ready  out  1             bridge can accept a request
// - req_we     in   1             1 = store, 0 = load
// - req_addr   in   ADDR_WIDTH    byte address
// - req_wdata  in   DATA_WIDTH    store data
// - req_strb   in   DATA_WIDTH/8  store byte enables
// - rsp_valid  out  1             response valid
// - rsp_ready  in   1             core accepts the response
// - rsp_rdata  out  DATA_WIDTH    load data; 0 for stores
// - rsp_err    out  1             bresp/rresp != axi4::OKAY, or timeout
// - bus        axi.master         awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready,
//                                 araddr/arvalid/arready, rdata/rresp/rvalid/rready
// BEHAVIOUR
// - States: IDLE, WRITE, WRESP, READ, RDATA, RESP. State is held in one register.
// - Reset: state=IDLE. All of awvalid, wvalid, bready, arvalid, rready, rsp_valid and rsp_err are 0. rsp_rdata=0.
// - Reset asserted mid-transaction abandons the transaction immediately; the slave shares the reset.
// - req_ready=1 only in IDLE. At most one transaction is outstanding.
// - IDLE: on req_valid & req_ready, capture addr/wdata/strb into registers; go to WRITE if req_we, else READ.
// - WRITE: awvalid and wvalid rise in the cycle after acceptance.
//   - Each valid drops independently on its own handshake.
//   - AW and W may complete in the same cycle or in either order.
//   - bready=1 throughout WRITE and WRESP.
//   - When both handshakes are done: go to WRESP, or straight to RESP if bvalid is already seen in that cycle.
// - WRESP: on bvalid & bready, capture err=(bresp!=OKAY) and go to RESP.
// - READ: arvalid=1 and rready=1.
//   - rready must be high here because the RAM slave ties arready to rready; this is mandatory to avoid deadlock.
//   - On the AR handshake, arvalid drops and the state goes to RDATA.
// - RDATA: rready=1. On rvalid, capture rdata and err=(rresp!=OKAY), then go to RESP.
// - RESP: rsp_valid=1 and outputs are held stable until rsp_ready. Then go to IDLE.
//   - A new request is accepted no earlier than the cycle after rsp handshake (req_ready registered from state).
// - Latency against the RAM with zero stall:
//   - Store: accept at c0, AW/W at c1, B at c2, rsp_valid at c3.
//   - Load: accept at c0, AR at c1, R at c2, rsp_valid at c3.
// - AXI rule: no valid is deasserted before its handshake (except on timeout, below). Payloads are stable while valid.
// - Addresses are passed through unaligned and unmodified; the slave ignores addr[1:0].
// CONFIGURATION
// - `define MEM_BRIDGE_TIMEOUT_EN present:
//   - A $clog2(TIMEOUT+1)-bit counter clears on entry to WRITE or READ and increments in WRITE, WRESP, READ and RDATA.
//   - On reaching TIMEOUT: all AXI valids and readies drop, the state goes to RESP with rsp_err=1 and rsp_rdata=0.
//   - This is the sole permitted protocol violation, for dead-slave debug.
// - `define MEM_BRIDGE_TIMEOUT_EN absent: no counter. The bridge waits indefinitely. The TIMEOUT parameter is ignored.
// STRUCTURE
// - The axi4 package supplies resp_t and the OKAY/EXOKAY/SLVERR/DECERR constants. Add resp_t there if it is missing.
// - The state enum state_t is local to the module.
// - No sub-module: the FSM and capture registers are flat.
// TESTING (bench drives the bridge into the block RAM, DATA_DEPTH=1024)
// - Store 0xDEADBEEF at 0x10 with strb=4'hF, then load 0x10.
//   -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at c3 of each transaction.
// - Store 0x000000AA at 0x10 with strb=4'h1 over the previous value, then load.
//   -> rsp_rdata=0xDEADBEAA.
// - Slave model delays wready by 3 cycles and awready by 0.
//   -> awvalid drops at c1, wvalid holds until c4, exactly one response, no duplicate AW.
// - Slave model returns rresp=SLVERR on a load.
//   -> rsp_err=1. The next load to the RAM returns rsp_err=0.
// - Hold rsp_ready=0 for 5 cycles.
//   -> rsp_valid/rdata stay stable, req_ready=0, no AXI activity. Release -> IDLE the next cycle.
// - Assert rst mid-WRITE (awvalid=1).
//   -> all valids 0 asynchronously and state=IDLE. With MEM_BRIDGE_TIMEOUT_EN and a silent slave at TIMEOUT=8:
//   -> rsp_err=1 on rsp_valid 9 cycles after acceptance.

Source files
------------

// File: rtl/axi4_pkg.sv
// AXI4 shared types: the response code enum used by every AXI4-Lite master and slave.
package axi4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding AXI4-Lite master turning core load/store requests into AW/W/B or AR/R.
// Optional MEM_BRIDGE_TIMEOUT_EN abandons a stalled transaction after TIMEOUT cycles with rsp_err=1.
module mem_bridge
  import axi4::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef MEM_BRIDGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 256
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   bus_awaddr,
  output logic                    bus_awvalid,
  input  logic                    bus_awready,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb,
  output logic                    bus_wvalid,
  input  logic                    bus_wready,
  input  resp_t                   bus_bresp,
  input  logic                    bus_bvalid,
  output logic                    bus_bready,
  output logic [ADDR_WIDTH-1:0]   bus_araddr,
  output logic                    bus_arvalid,
  input  logic                    bus_arready,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  resp_t                   bus_rresp,
  input  logic                    bus_rvalid,
  output logic                    bus_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

  state_t                state_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  aw_done, w_done, timeout_hit;

  // A channel counts as done once its valid is gone or is being accepted this cycle.
  assign aw_done = !awvalid_q || bus_awready;
  assign w_done  = !wvalid_q || bus_wready;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_q;
  logic             busy;

  assign busy        = state_q inside {WRITE, WRESP, READ, RDATA};
  assign timeout_hit = busy && (tmo_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         tmo_q <= '0;
    else if (req_valid && req_ready) tmo_q <= '0;
    else if (busy)                   tmo_q <= tmo_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign bus_awaddr  = addr_q;
  assign bus_araddr  = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_wstrb   = strb_q;
  assign bus_awvalid = awvalid_q;
  assign bus_wvalid  = wvalid_q;
  assign bus_bready  = bready_q;
  assign bus_arvalid = arvalid_q;
  assign bus_rready  = rready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      // NOTE: payload registers are reset too so the bus never shows X while idle.
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            strb_q  <= req_strb;
            if (req_we) begin
              state_q   <= WRITE;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              bready_q  <= 1'b1;
            end else begin
              state_q   <= READ;
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus_awready) awvalid_q <= 1'b0;
          if (bus_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            if (bus_bvalid) begin
              bready_q    <= 1'b0;
              rsp_err_q   <= (bus_bresp != OKAY);
              rsp_rdata_q <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= WRESP;
            end
          end
        end
        WRESP: begin
          if (bus_bvalid) begin
            bready_q    <= 1'b0;
            rsp_err_q   <= (bus_bresp != OKAY);
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        READ: begin
          if (bus_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= RDATA;
          end
        end
        RDATA: begin
          if (bus_rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= bus_rdata;
            rsp_err_q   <= (bus_rresp != OKAY);
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // NOTE: the last nonblocking assignment wins, so an expiring timeout overrides the case above.
      if (timeout_hit) begin
        awvalid_q   <= 1'b0;
        wvalid_q    <= 1'b0;
        bready_q    <= 1'b0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_valid_q <= 1'b1;
        state_q     <= RESP;
      end
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge against a behavioural AXI4-Lite block RAM with W-stall, SLVERR and silent modes.
// Under MEM_BRIDGE_TIMEOUT_EN the bridge is built with TIMEOUT=8 and a silent-slave store is also checked.
module tb_mem_bridge;
  import axi4::*;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb  = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic [31:0] bus_awaddr, bus_wdata, bus_araddr, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_awvalid, bus_awready, bus_wvalid, bus_wready, bus_bvalid, bus_bready;
  logic        bus_arvalid, bus_arready, bus_rvalid, bus_rready;
  resp_t       bus_bresp, bus_rresp;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mem_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
`ifdef MEM_BRIDGE_TIMEOUT_EN
    ,
    .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid), .bus_awready(bus_awready),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
    .bus_bresp(bus_bresp), .bus_bvalid(bus_bvalid), .bus_bready(bus_bready),
    .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
    .bus_rdata(bus_rdata), .bus_rresp(bus_rresp), .bus_rvalid(bus_rvalid), .bus_rready(bus_rready)
  );

  // Behavioural block RAM slave (1024 words); arready is tied to rready like the real RAM.
  logic [31:0] mem [0:1023];
  logic        aw_taken, w_taken, bvalid_r, rvalid_r;
  logic [31:0] aw_addr_r, wdata_r, rdata_r;
  logic [3:0]  wstrb_r;
  resp_t       rresp_r;
  int          w_cnt;
  int          w_delay     = 0;
  logic        silent      = 1'b0;
  logic        rerr        = 1'b0;
  int          aw_hs_cnt   = 0;
  int          w_hs_cnt    = 0;
  int          b_hs_cnt    = 0;
  int          ar_hs_cnt   = 0;
  logic [31:0] last_awaddr = '0;
  logic [31:0] last_araddr = '0;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_have, w_have;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  assign bus_awready = !silent && !aw_taken && !bvalid_r;
  assign bus_wready  = !silent && bus_wvalid && !w_taken && !bvalid_r && (w_cnt >= w_delay);
  assign bus_bvalid  = bvalid_r;
  assign bus_bresp   = OKAY;
  assign bus_arready = !silent && bus_rready && !rvalid_r;
  assign bus_rvalid  = rvalid_r;
  assign bus_rdata   = rdata_r;
  assign bus_rresp   = rresp_r;

  assign aw_hs   = bus_awvalid && bus_awready;
  assign w_hs    = bus_wvalid && bus_wready;
  assign b_hs    = bus_bvalid && bus_bready;
  assign ar_hs   = bus_arvalid && bus_arready;
  assign r_hs    = bus_rvalid && bus_rready;
  assign aw_have = aw_taken || aw_hs;
  assign w_have  = w_taken || w_hs;
  assign wr_addr = aw_taken ? aw_addr_r : bus_awaddr;
  assign wr_data = w_taken ? wdata_r : bus_wdata;
  assign wr_strb = w_taken ? wstrb_r : bus_wstrb;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_taken  <= 1'b0;
      w_taken   <= 1'b0;
      bvalid_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      w_cnt     <= 0;
      aw_addr_r <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      rdata_r   <= '0;
      rresp_r   <= OKAY;
    end else begin
      if (b_hs) begin
        bvalid_r <= 1'b0;
        b_hs_cnt <= b_hs_cnt + 1;
      end
      if (r_hs) rvalid_r <= 1'b0;
      if (aw_hs) begin
        aw_hs_cnt   <= aw_hs_cnt + 1;
        last_awaddr <= bus_awaddr;
      end
      if (w_hs) w_hs_cnt <= w_hs_cnt + 1;
      if (aw_have && w_have) begin
        mem[wr_addr[11:2]] <= merge(mem[wr_addr[11:2]], wr_data, wr_strb);
        bvalid_r <= 1'b1;
        aw_taken <= 1'b0;
        w_taken  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_taken  <= 1'b1;
          aw_addr_r <= bus_awaddr;
        end
        if (w_hs) begin
          w_taken <= 1'b1;
          wdata_r <= bus_wdata;
          wstrb_r <= bus_wstrb;
        end
      end
      w_cnt <= (bus_wvalid && !w_taken && !w_hs) ? w_cnt + 1 : 0;
      if (ar_hs) begin
        ar_hs_cnt   <= ar_hs_cnt + 1;
        last_araddr <= bus_araddr;
        rvalid_r    <= 1'b1;
        rdata_r     <= mem[bus_araddr[11:2]];
        rresp_r     <= rerr ? SLVERR : OKAY;
      end
    end
  end

  logic aw_hist [0:63];
  logic w_hist  [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction: cycle 0 is the acceptance cycle, latency counts cycles until rsp_valid is seen.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input int hold, input int exp_lat,
                     input logic [31:0] exp_data, input logic exp_err, input string tag);
    int lat;
    int hs0;
    @(negedge clk);
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    lat = 1;
    aw_hist[1] = bus_awvalid;
    w_hist[1]  = bus_wvalid;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      aw_hist[lat] = bus_awvalid;
      w_hist[lat]  = bus_wvalid;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rsp_rdata"}, rsp_rdata, exp_data);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    hs0 = aw_hs_cnt + w_hs_cnt + b_hs_cnt + ar_hs_cnt;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold rsp_rdata"}, rsp_rdata, exp_data);
      check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      check({tag, " hold axi valids"},
            32'({bus_awvalid, bus_wvalid, bus_arvalid, bus_bready, bus_rready}), 32'd0);
      check({tag, " hold axi handshakes"},
            32'(aw_hs_cnt + w_hs_cnt + b_hs_cnt + ar_hs_cnt - hs0), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " rsp_valid after handshake"}, 32'(rsp_valid), 32'd0);
    check({tag, " req_ready after handshake"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int aw0, b0;

    repeat (2) @(negedge clk);
    check("reset awvalid", 32'(bus_awvalid), 32'd0);
    check("reset wvalid", 32'(bus_wvalid), 32'd0);
    check("reset bready", 32'(bus_bready), 32'd0);
    check("reset arvalid", 32'(bus_arvalid), 32'd0);
    check("reset rready", 32'(bus_rready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 3, 32'h0, 1'b0, "st_full");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 3, 32'hDEADBEEF, 1'b0, "ld_full");
    txn(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, 3, 32'h0, 1'b0, "st_byte0");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 3, 32'hDEADBEAA, 1'b0, "ld_byte0_hold");

    w_delay = 3;
    aw0 = aw_hs_cnt;
    b0  = b_hs_cnt;
    txn(1'b1, 32'h24, 32'h12345678, 4'hF, 0, 6, 32'h0, 1'b0, "st_wstall");
    check("wstall awvalid c1", 32'(aw_hist[1]), 32'd1);
    check("wstall awvalid c2", 32'(aw_hist[2]), 32'd0);
    check("wstall wvalid c4", 32'(w_hist[4]), 32'd1);
    check("wstall wvalid c5", 32'(w_hist[5]), 32'd0);
    check("wstall aw count", 32'(aw_hs_cnt - aw0), 32'd1);
    check("wstall b count", 32'(b_hs_cnt - b0), 32'd1);
    w_delay = 0;
    txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 3, 32'h12345678, 1'b0, "ld_wstall");

    rerr = 1'b1;
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 3, 32'hDEADBEAA, 1'b1, "ld_slverr");
    rerr = 1'b0;
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 3, 32'hDEADBEAA, 1'b0, "ld_after_err");

    txn(1'b1, 32'h33, 32'h0BADF00D, 4'hF, 0, 3, 32'h0, 1'b0, "st_unaligned");
    check("unaligned awaddr", last_awaddr, 32'h33);
    txn(1'b0, 32'h31, 32'h0, 4'h0, 0, 3, 32'h0BADF00D, 1'b0, "ld_unaligned");
    check("unaligned araddr", last_araddr, 32'h31);

    silent = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h55;
    req_strb  = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    @(negedge clk);
    check("midrst awvalid before", 32'(bus_awvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst awvalid", 32'(bus_awvalid), 32'd0);
    check("midrst wvalid", 32'(bus_wvalid), 32'd0);
    check("midrst bready", 32'(bus_bready), 32'd0);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst    = 1'b0;
    silent = 1'b0;
    txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 3, 32'h12345678, 1'b0, "ld_after_rst");

`ifdef MEM_BRIDGE_TIMEOUT_EN
    silent = 1'b1;
    txn(1'b1, 32'h50, 32'h1, 4'hF, 0, 9, 32'h0, 1'b1, "st_timeout");
    silent = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of run, expected finish before 100000");
    $fatal(1);
  end

endmodule
